// File: rtl/hpu_pkg.sv
// Shared HPU constants: OAM geometry, vertical-blank threshold and the OAM DMA state encoding.
// The sprite loader imports the same package so both sides agree on the record layout.
package hpu_pkg;

    localparam logic [15:0] OAM_BASE         = 16'h3000;
    localparam int          SPRITE_DATA_SIZE = 4;
    localparam int          NUM_SPRITES      = 64;
    localparam int          OAM_IDX_W        = $clog2(NUM_SPRITES);
    localparam logic [9:0]  ACTIVE_LINES     = 10'd480;

    // Byte offsets inside one OAM record
    localparam logic [1:0]  OAM_Y    = 2'd0;
    localparam logic [1:0]  OAM_TILE = 2'd1;
    localparam logic [1:0]  OAM_X    = 2'd2;
    localparam logic [1:0]  OAM_PAL  = 2'd3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } dma_state_t;

endpackage

// File: rtl/hpu_oam_dma.sv
// Copies sprite attribute records from CPU-side memory into OAM, one byte per read/write pair.
// VRAM writes are only issued during vertical blank; the FSM parks in WRITE until vblank arrives.
module hpu_oam_dma
    import hpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  true_line,
    input  logic        start,
    input  logic [7:0]  src_page,
    input  logic [5:0]  first_sprite,
    input  logic [6:0]  sprite_count,
    output logic        src_req,
    output logic [15:0] src_addr_out,
    input  logic        src_ack,
    input  logic [7:0]  src_data_in,
    output logic        vram_we,
    output logic [15:0] vram_addr_out,
    output logic [7:0]  vram_data_out,
    output logic        busy,
    output logic        done
);

    dma_state_t           state_reg, state_next;
    logic [7:0]           byte_idx_reg;
    logic [7:0]           last_idx_reg;
    logic [7:0]           src_page_reg;
    logic [OAM_IDX_W-1:0] first_sprite_reg;
    logic [7:0]           data_reg;

    logic                 vblank;
    logic [6:0]           count_clamped;
    logic [7:0]           last_idx_next;

    // The record index wraps inside the 64-entry table, so the address never leaves OAM.
    function automatic logic [15:0] oam_addr(input logic [OAM_IDX_W-1:0] first,
                                             input logic [7:0]           idx);
        logic [OAM_IDX_W-1:0] rec;
        rec = first + idx[7:2];
        return OAM_BASE + {8'h00, rec, idx[1:0]};
    endfunction

    function automatic logic [6:0] clamp_count(input logic [6:0] c);
        return (c > 7'(NUM_SPRITES)) ? 7'(NUM_SPRITES) : c;
    endfunction

    assign vblank        = (true_line >= ACTIVE_LINES);
    assign count_clamped = clamp_count(sprite_count);
    // A clamped count of 64 has zero low bits, and 0 - 1 yields 255, the last byte of a full table.
    assign last_idx_next = {count_clamped[5:0], 2'b00} - 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg        <= IDLE;
            byte_idx_reg     <= 8'd0;
            last_idx_reg     <= 8'd0;
            src_page_reg     <= 8'd0;
            first_sprite_reg <= '0;
            data_reg         <= 8'd0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        src_page_reg     <= src_page;
                        first_sprite_reg <= first_sprite;
                        last_idx_reg     <= last_idx_next;
                        byte_idx_reg     <= 8'd0;
                    end
                end
                READ: begin
                    if (src_ack) begin
                        data_reg <= src_data_in;
                    end
                end
                WRITE: begin
                    if (vblank) begin
                        byte_idx_reg <= byte_idx_reg + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    state_next = (count_clamped == 7'd0) ? DONE : READ;
                end
            end
            READ: begin
                if (src_ack) begin
                    state_next = WRITE;
                end
            end
            WRITE: begin
                if (vblank) begin
                    state_next = (byte_idx_reg == last_idx_reg) ? DONE : READ;
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        src_req       = 1'b0;
        src_addr_out  = 16'h0000;
        vram_we       = 1'b0;
        vram_addr_out = 16'h0000;
        vram_data_out = 8'h00;
        busy          = 1'b0;
        done          = 1'b0;
        case (state_reg)
            READ: begin
                busy         = 1'b1;
                src_req      = 1'b1;
                src_addr_out = {src_page_reg, 8'h00} + {8'h00, byte_idx_reg};
            end
            WRITE: begin
                busy          = 1'b1;
                vram_we       = vblank;
                vram_addr_out = oam_addr(first_sprite_reg, byte_idx_reg);
                vram_data_out = data_reg;
            end
            DONE: begin
                busy = 1'b1;
                done = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_hpu_oam_dma.sv
// Bench for hpu_oam_dma: a table of directed transfers plus hand sequences for vblank stall,
// start-while-busy, start-during-done and reset in the middle of a transfer.
module tb_hpu_oam_dma;

    logic        clk = 1'b0;
    logic        reset;
    logic [9:0]  true_line;
    logic        start;
    logic [7:0]  src_page;
    logic [5:0]  first_sprite;
    logic [6:0]  sprite_count;
    logic        src_req;
    logic [15:0] src_addr_out;
    logic        src_ack;
    logic [7:0]  src_data_in;
    logic        vram_we;
    logic [15:0] vram_addr_out;
    logic [7:0]  vram_data_out;
    logic        busy;
    logic        done;

    hpu_oam_dma dut (
        .clk           (clk),
        .reset         (reset),
        .true_line     (true_line),
        .start         (start),
        .src_page      (src_page),
        .first_sprite  (first_sprite),
        .sprite_count  (sprite_count),
        .src_req       (src_req),
        .src_addr_out  (src_addr_out),
        .src_ack       (src_ack),
        .src_data_in   (src_data_in),
        .vram_we       (vram_we),
        .vram_addr_out (vram_addr_out),
        .vram_data_out (vram_data_out),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Source memory model: contents depend on the low address byte only
    logic [7:0]  src_mem [256];
    logic [15:0] wr_a[$];
    logic [7:0]  wr_d[$];
    logic [15:0] rd_q[$];
    int          done_cnt  = 0;
    int          wait_cfg  = 0;
    logic        stray_ack = 1'b0;
    logic        prev_req  = 1'b0;
    logic [15:0] held_addr = 16'h0;
    int          wcnt      = 0;

    // Source responder: acks after wait_cfg cycles of request, data valid with the ack
    always @(negedge clk) begin
        if (src_req) begin
            if (!prev_req) begin
                held_addr = src_addr_out;
                wcnt      = 0;
            end
            if (wcnt >= wait_cfg) begin
                src_ack     = 1'b1;
                src_data_in = src_mem[src_addr_out[7:0]];
                check("src_addr_hold", src_addr_out, held_addr);
                rd_q.push_back(src_addr_out);
            end else begin
                src_ack     = 1'b0;
                src_data_in = 8'hEE;
                wcnt++;
            end
        end else begin
            src_ack     = stray_ack;
            src_data_in = 8'hAA;
        end
        prev_req = src_req;
    end

    // Write/done monitor, sampled after inputs driven on the falling edge have settled
    always @(negedge clk) begin
        #1;
        if (vram_we) begin
            wr_a.push_back(vram_addr_out);
            wr_d.push_back(vram_data_out);
            check("we_in_vblank", 32'(true_line >= 10'd480), 1);
        end
        if (done) done_cnt++;
    end

    task automatic clear_logs();
        wr_a.delete();
        wr_d.delete();
        rd_q.delete();
    endtask

    task automatic pulse_start(input logic [9:0] line, input logic [7:0] page,
                               input logic [5:0] first, input logic [6:0] count);
        @(negedge clk);
        true_line    = line;
        src_page     = page;
        first_sprite = first;
        sprite_count = count;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output int cycles);
        cycles = 0;
        while (done !== 1'b1 && cycles < limit) begin
            @(negedge clk);
            cycles++;
        end
        check("done_seen", 32'(done), 1);
    endtask

    task automatic verify_writes(input int first, input int page, input int n);
        int m;
        int exp_a;
        check("n_writes", wr_a.size(), n);
        check("n_reads", rd_q.size(), n);
        m = (wr_a.size() < n) ? wr_a.size() : n;
        for (int k = 0; k < m; k++) begin
            exp_a = 'h3000 + (((first + k / 4) % 64) * 4) + (k % 4);
            check("wr_addr", wr_a[k], exp_a);
            check("wr_data", wr_d[k], src_mem[k & 255]);
        end
        m = (rd_q.size() < n) ? rd_q.size() : n;
        for (int k = 0; k < m; k++) begin
            check("src_addr", rd_q[k], ((page * 256) + k) & 'hFFFF);
        end
    endtask

    typedef struct {
        logic [9:0] line;
        logic [7:0] page;
        logic [5:0] first;
        logic [6:0] count;
        int         wait_cyc;
        logic       stray;
        int         exp_writes;
    } vec_t;

    vec_t vecs[5];

    initial begin
        int cyc;
        int done_before;

        vecs[0] = '{10'd490, 8'h40, 6'd0,  7'd1,   0, 1'b0, 4};
        vecs[1] = '{10'd490, 8'h40, 6'd63, 7'd2,   0, 1'b0, 8};
        vecs[2] = '{10'd500, 8'h12, 6'd5,  7'd3,   3, 1'b1, 12};
        vecs[3] = '{10'd490, 8'h40, 6'd0,  7'd0,   0, 1'b0, 0};
        vecs[4] = '{10'd524, 8'h40, 6'd0,  7'd100, 0, 1'b0, 256};

        for (int i = 0; i < 256; i++) src_mem[i] = 8'((i * 7) + 1);
        src_mem[0] = 8'h10;
        src_mem[1] = 8'h20;
        src_mem[2] = 8'h30;
        src_mem[3] = 8'h03;

        reset        = 1'b1;
        true_line    = 10'd0;
        start        = 1'b0;
        src_page     = 8'h00;
        first_sprite = 6'd0;
        sprite_count = 7'd0;
        src_ack      = 1'b0;
        src_data_in  = 8'h00;

        repeat (3) @(negedge clk);
        check("rst_src_req", 32'(src_req), 0);
        check("rst_vram_we", 32'(vram_we), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_src_addr", 32'(src_addr_out), 0);
        check("rst_vram_addr", 32'(vram_addr_out), 0);
        check("rst_vram_data", 32'(vram_data_out), 0);
        reset = 1'b0;

        for (int v = 0; v < 5; v++) begin
            clear_logs();
            wait_cfg    = vecs[v].wait_cyc;
            stray_ack   = vecs[v].stray;
            done_before = done_cnt;
            pulse_start(vecs[v].line, vecs[v].page, vecs[v].first, vecs[v].count);
            wait_done(2000, cyc);
            if (vecs[v].count == 7'd0) check("zero_cnt_latency", 32'(cyc <= 2), 1);
            @(negedge clk);
            check("busy_after", 32'(busy), 0);
            check("single_done", done_cnt, done_before + 1);
            verify_writes(int'(vecs[v].first), int'(vecs[v].page), vecs[v].exp_writes);
            $display("vec %0d: count=%0d writes=%0d cycles=%0d", v, vecs[v].count, wr_a.size(), cyc);
        end
        stray_ack = 1'b0;

        // Transfer started outside vblank stalls in WRITE until line 480
        clear_logs();
        wait_cfg = 0;
        pulse_start(10'd100, 8'h40, 6'd0, 7'd1);
        repeat (20) @(negedge clk);
        check("stall_no_writes", wr_a.size(), 0);
        check("stall_busy", 32'(busy), 1);
        check("stall_one_read", rd_q.size(), 1);
        check("stall_we", 32'(vram_we), 0);
        check("stall_addr", 32'(vram_addr_out), 'h3000);
        check("stall_data", 32'(vram_data_out), 'h10);
        true_line = 10'd480;
        wait_done(100, cyc);
        @(negedge clk);
        verify_writes(0, 'h40, 4);
        $display("seq vblank_stall: writes=%0d", wr_a.size());

        // Second start while busy, and start coincident with done, are both ignored
        clear_logs();
        wait_cfg    = 3;
        done_before = done_cnt;
        pulse_start(10'd490, 8'h40, 6'd0, 7'd1);
        repeat (2) @(negedge clk);
        pulse_start(10'd490, 8'h77, 6'd20, 7'd5);
        wait_done(200, cyc);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check("ignore_busy", 32'(busy), 0);
        check("ignore_done_cnt", done_cnt, done_before + 1);
        verify_writes(0, 'h40, 4);
        $display("seq start_ignored: writes=%0d reads=%0d", wr_a.size(), rd_q.size());

        // Reset while parked in WRITE aborts with no strobe and no done
        clear_logs();
        wait_cfg    = 0;
        done_before = done_cnt;
        pulse_start(10'd100, 8'h40, 6'd0, 7'd2);
        repeat (5) @(negedge clk);
        check("pre_rst_busy", 32'(busy), 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_we", 32'(vram_we), 0);
        check("abort_busy", 32'(busy), 0);
        check("abort_req", 32'(src_req), 0);
        true_line = 10'd490;
        repeat (5) @(negedge clk);
        check("abort_no_writes", wr_a.size(), 0);
        check("abort_no_done", done_cnt, done_before);
        clear_logs();
        pulse_start(10'd490, 8'h40, 6'd0, 7'd1);
        wait_done(100, cyc);
        @(negedge clk);
        verify_writes(0, 'h40, 4);
        $display("seq reset_abort: restart writes=%0d", wr_a.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hpu_oam_dma.md
Name: hpu_oam_dma

Overview:
- Writer-side companion to the sprite loader. Copies sprite attribute records from a CPU-side source memory into the HPU sprite object memory (OAM) in VRAM.
- OAM is 64 records × 4 bytes at 16'h3000. Record byte order: 0=y, 1=tile, 2=x, 3=palette.
- VRAM writes occur only during vertical blank, so they never collide with HPU tile/sprite reads.
- The block sits between the CPU bus bridge and the VRAM write port.

Parameters:
- OAM_BASE, 16'h3000, VRAM byte address of OAM record 0.
- SPRITE_DATA_SIZE, 4, bytes per OAM record.
- NUM_SPRITES, 64, OAM record count; index width is clog2 = 6.
- ACTIVE_LINES, 480, first true_line value that counts as vertical blank.

Ports:
- clk, input, 1, system clock.
- reset, input, 1, reset; synchronous, active-high.
- true_line, input, 10, current raster line in 640x480 timing (0..524).
- start, input, 1, one-cycle request to begin a transfer; ignored while busy.
- src_page, input, 8, source base address high byte; source base = {src_page, 8'h00}.
- first_sprite, input, 6, OAM index of the first destination record.
- sprite_count, input, 7, number of records to copy; 0 = no-op; values >64 are clamped to 64.
- src_req, output, 1, source read request.
- src_addr_out, output, 16, source read address.
- src_ack, input, 1, source read complete; src_data_in is valid in the same cycle.
- src_data_in, input, 8, source read data.
- vram_we, output, 1, VRAM write strobe, one cycle per byte.
- vram_addr_out, output, 16, VRAM write address.
- vram_data_out, output, 8, VRAM write data.
- busy, output, 1, high from the cycle after an accepted start until done.
- done, output, 1, one-cycle pulse when a transfer completes.

Behaviour:
- Reset values: state=IDLE; src_req, vram_we, busy, done = 0; src_addr_out, vram_addr_out, vram_data_out = 0.
- Reset asserted mid-transfer:
  - Aborts at the next clock edge with no partial write strobe.
  - OAM bytes already written remain written.
  - No done pulse is issued.
- vblank = (true_line >= ACTIVE_LINES). Evaluated combinationally each cycle.
- start is accepted only in IDLE:
  - Latches src_page, first_sprite and sprite_count (after clamping).
  - Clears byte_idx (8 bits, counts 0..4*count-1).
- State machine:
  - IDLE: on start with count≠0 → READ. On start with count=0 → DONE.
  - READ:
    - src_req=1 and src_addr_out = {src_page,8'h00} + byte_idx, with 16-bit wrap.
    - Address and request are held stable until src_ack.
    - When src_ack is sampled high: latch src_data_in into the data register and go to WRITE.
    - Reads may occur outside vblank.
  - WRITE:
    - If vblank: vram_we=1 for exactly this cycle.
    - vram_addr_out = OAM_BASE + ((first_sprite + byte_idx[7:2]) mod 64)*4 + byte_idx[1:0]. The OAM index wraps within 64 records and never leaves the OAM range.
    - vram_data_out = latched byte, copied verbatim (no palette masking).
    - Then byte_idx++. If it was the last byte → DONE, else → READ.
    - If not vblank: hold in WRITE with vram_we=0, address and data held, until vblank rises.
  - DONE: done=1 for one cycle, busy=0 next cycle → IDLE.
- busy is 1 in READ and WRITE, and also 1 in DONE.
- Latency:
  - src_ack in cycle N → vram_we in cycle N+1 if vblank.
  - Next src_req is asserted in cycle N+2.
  - Minimum 2 cycles/byte plus source wait states.
- Transfers longer than one vblank pause in WRITE and resume in the next frame's vblank. Byte order is preserved and no byte is skipped or repeated.
- start asserted while busy: ignored, with no effect on latched arguments.
- start asserted in the same cycle as done: ignored, because the FSM is not yet in IDLE.
- src_ack asserted while src_req=0: ignored.

Decomposition:
- Shared package hpu_pkg holds:
  - OAM_BASE, SPRITE_DATA_SIZE, NUM_SPRITES, ACTIVE_LINES.
  - The OAM byte offset constants (OAM_Y=0, OAM_TILE=1, OAM_X=2, OAM_PAL=3).
  - The state enum dma_state_t {IDLE, READ, WRITE, DONE}.
- The hpu sprite loader imports the same constants.
- Single module; no sub-module is needed. The address generator stays inline as a combinational function.

Test Plan:
- In vblank (true_line=490), start, src_page=8'h40, first_sprite=0, sprite_count=1, zero-wait acks, source bytes 10,20,30,03 → 4 vram_we pulses at 16'h3000..3003 with data 10,20,30,03; one done pulse; busy low afterwards.
- first_sprite=63, sprite_count=2 → writes to 16'h30FC..30FF, then 16'h3000..3003 (index wrap); src addresses 16'h4000..4007.
- Start with true_line=100, sprite_count=1 → first READ completes, vram_we stays 0 until true_line reaches 480, then all 4 bytes are written in order; no writes while true_line<480.
- Source wait states (src_ack delayed 3 cycles) → src_req and src_addr_out are held stable; data equals src_data_in at the ack cycle.
- sprite_count=0 → done pulses within 2 cycles of start, no vram_we. sprite_count=100 → exactly 256 writes covering 16'h3000..30FF.
- start re-pulsed while busy is ignored. Reset asserted mid-WRITE → next cycle vram_we=0, busy=0, no done pulse, IDLE accepts a new start.
